multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter ILLEGAL_TRAP, default 0: 0 = illegal opcode retires as NOP; 1 = illegal opcode enters HALT.
REQ-002 SHALL have one clock; reset is synchronous and active-high.
REQ-003 SHALL have port Clk, input, 1, the only clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port Instr, input, 32, instruction word from memory, valid in IFETCH.
REQ-006 SHALL have port Zero, input, 1, ALU zero flag from the ALU stage, sampled combinationally in EXEC.
REQ-007 SHALL have port Instr_LdEn, output, 1, instruction register load enable.
REQ-008 SHALL have port PC_LdEn, output, 1, PC load enable.
REQ-009 SHALL have port PC_sel, output, 1, next-PC source: 0 = PC+4, 1 = PC+4+(Immed<<2).
REQ-010 SHALL have port ALU_Bin_SEL, output, 1, ALU B operand source: 0 = RF_B, 1 = Immed.
REQ-011 SHALL have port ALU_func, output, 4, ALU operation: add 0000, sub 0001, and 0010, or 0011.
REQ-012 SHALL have port RF_WrEn, output, 1, register file write enable.
REQ-013 SHALL have port RF_WrData_sel, output, 1, write-back source: 0 = ALU_out, 1 = memory data.
REQ-014 SHALL have port MEM_WrEn, output, 1, data memory write enable.
REQ-015 SHALL have port Illegal, output, 1, one-cycle pulse in DECODE on an unknown opcode.
REQ-016 SHALL have port State, output, 3, current state code, for debug.

Function
REQ-017 SHALL use state codes IFETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7.
REQ-018 SHALL capture Instr into internal instr_q on the rising edge that leaves IFETCH.
- Instr_LdEn SHALL be 1 only in IFETCH.
REQ-019 SHALL decode opcode instr_q[31:26] as follows:
- 100000: R-type; ALU_func = instr_q[3:0].
- 110000 addi, 110010 andi, 110011 ori: ALU_func = 0000, 0010, 0011 respectively.
- 001111 lw, 011111 sw: ALU_func = add.
- 010000 beq, 010001 bne: ALU_func = sub.
- 111111: b.
- 000000: nop.
- Any other opcode: illegal.
REQ-020 SHALL use the following transitions:
- IFETCH->DECODE always.
- DECODE->IFETCH for nop or illegal (ILLEGAL_TRAP=0); DECODE->HALT for illegal (ILLEGAL_TRAP=1); otherwise DECODE->EXEC.
- EXEC->WB for R-type and immediate ops; EXEC->MEM for lw and sw; EXEC->IFETCH for branches.
- MEM->WB for lw; MEM->IFETCH for sw.
- WB->IFETCH always.
- HALT SHALL be left only by Reset.
REQ-021 SHALL hold ALU_Bin_SEL and ALU_func stable from EXEC through WB for the instruction.
- ALU_Bin_SEL = 1 for immediate ops, lw and sw; 0 otherwise.
REQ-022 SHALL assert PC_LdEn for exactly one cycle per retired instruction, in its final state:
- nop/illegal: DECODE.
- branch: EXEC.
- sw: MEM.
- others: WB.
REQ-023 SHALL assert PC_sel=1 with that PC_LdEn for b always, for beq when Zero=1, and for bne when Zero=0; otherwise PC_sel=0.
REQ-024 SHALL assert RF_WrEn only in WB, with RF_WrData_sel=1 for lw and 0 otherwise.
REQ-025 SHALL assert MEM_WrEn only in MEM for sw.
REQ-026 SHALL have latency IFETCH to next IFETCH of:
- nop/illegal: 2 cycles.
- branch: 3 cycles.
- R-type, immediate ops and sw: 4 cycles.
- lw: 5 cycles.
REQ-027 SHALL hold all enables (PC_LdEn, RF_WrEn, MEM_WrEn, Instr_LdEn) and Illegal at 0 in HALT.
REQ-028 SHALL ignore Zero outside EXEC and Instr outside IFETCH.

Reset
REQ-029 SHALL, on Clk edge with Reset=1, set State to IFETCH and instr_q to 32'h0, regardless of current state, including mid-instruction and HALT.
REQ-030 SHALL force every output to 0 while Reset=1, including Instr_LdEn, ALU_func=0000 and State=0.
REQ-031 SHALL NOT perform RF_WrEn, MEM_WrEn or PC_LdEn in the cycle after Reset deasserts.
- That cycle is IFETCH, with only Instr_LdEn=1.

Verification
REQ-032 SHALL cover: R-type add (opcode 100000, func 0000) -> states 0,1,2,4,0; ALU_Bin_SEL=0 and ALU_func=0000 in EXEC; RF_WrEn=1 and PC_LdEn=1 in WB only.
REQ-033 SHALL cover: lw (001111) -> states 0,1,2,3,4; RF_WrData_sel=1 with RF_WrEn in WB; ALU_Bin_SEL=1; MEM_WrEn never 1.
REQ-034 SHALL cover: beq with Zero=1 in EXEC -> PC_sel=1 and PC_LdEn=1 in EXEC, next state IFETCH; bne with Zero=1 -> PC_sel=0.
REQ-035 SHALL cover: illegal opcode 101010 with ILLEGAL_TRAP=0 -> Illegal=1 and PC_LdEn=1 in DECODE, back to IFETCH; with ILLEGAL_TRAP=1 -> State=7 held for 10 cycles with all enables 0.
REQ-036 SHALL cover: Reset asserted in MEM of sw -> MEM_WrEn=0 that cycle, State=0 next edge; Reset released -> next cycle IFETCH with only Instr_LdEn=1.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle CPU control unit: IFETCH/DECODE/EXEC/MEM/WB sequencer with an
// internal instruction register and an optional halt-on-illegal-opcode trap.
module multicycle_control #(
  parameter int unsigned ILLEGAL_TRAP = 0
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] Instr,
  input  logic        Zero,
  output logic        Instr_LdEn,
  output logic        PC_LdEn,
  output logic        PC_sel,
  output logic        ALU_Bin_SEL,
  output logic [3:0]  ALU_func,
  output logic        RF_WrEn,
  output logic        RF_WrData_sel,
  output logic        MEM_WrEn,
  output logic        Illegal,
  output logic [2:0]  State
);

  typedef enum logic [2:0] {
    S_IFETCH = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd7
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b100000;
  localparam logic [5:0] OP_ADDI  = 6'b110000;
  localparam logic [5:0] OP_ANDI  = 6'b110010;
  localparam logic [5:0] OP_ORI   = 6'b110011;
  localparam logic [5:0] OP_LW    = 6'b001111;
  localparam logic [5:0] OP_SW    = 6'b011111;
  localparam logic [5:0] OP_BEQ   = 6'b010000;
  localparam logic [5:0] OP_BNE   = 6'b010001;
  localparam logic [5:0] OP_B     = 6'b111111;
  localparam logic [5:0] OP_NOP   = 6'b000000;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_instr;

  logic       w_is_rtype, w_is_imm, w_is_lw, w_is_sw;
  logic       w_is_beq, w_is_bne, w_is_b, w_is_nop, w_is_illegal;
  logic       w_is_branch, w_branch_taken;
  logic [3:0] w_dec_func;
  logic       w_dec_bsel;
  logic       w_unused;

  logic       w_instr_ld, w_pc_ld, w_pc_sel, w_bsel, w_rf_wr, w_rf_sel, w_mem_wr, w_illegal;
  logic [3:0] w_alu_func;

  // Only the opcode and R-type function field steer control.
  assign w_unused = ^r_instr[25:4];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= S_IFETCH;
      r_instr <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == S_IFETCH) begin
        r_instr <= Instr;
      end
    end
  end

  always_comb begin
    w_is_rtype   = 1'b0;
    w_is_imm     = 1'b0;
    w_is_lw      = 1'b0;
    w_is_sw      = 1'b0;
    w_is_beq     = 1'b0;
    w_is_bne     = 1'b0;
    w_is_b       = 1'b0;
    w_is_nop     = 1'b0;
    w_is_illegal = 1'b0;
    w_dec_func   = 4'b0000;
    w_dec_bsel   = 1'b0;
    case (r_instr[31:26])
      OP_RTYPE: begin w_is_rtype = 1'b1; w_dec_func = r_instr[3:0]; end
      OP_ADDI:  begin w_is_imm = 1'b1; w_dec_bsel = 1'b1; w_dec_func = 4'b0000; end
      OP_ANDI:  begin w_is_imm = 1'b1; w_dec_bsel = 1'b1; w_dec_func = 4'b0010; end
      OP_ORI:   begin w_is_imm = 1'b1; w_dec_bsel = 1'b1; w_dec_func = 4'b0011; end
      OP_LW:    begin w_is_lw = 1'b1; w_dec_bsel = 1'b1; end
      OP_SW:    begin w_is_sw = 1'b1; w_dec_bsel = 1'b1; end
      OP_BEQ:   begin w_is_beq = 1'b1; w_dec_func = 4'b0001; end
      OP_BNE:   begin w_is_bne = 1'b1; w_dec_func = 4'b0001; end
      OP_B:     w_is_b = 1'b1;
      OP_NOP:   w_is_nop = 1'b1;
      default:  w_is_illegal = 1'b1;
    endcase
  end

  assign w_is_branch    = w_is_beq | w_is_bne | w_is_b;
  assign w_branch_taken = w_is_b | (w_is_beq & Zero) | (w_is_bne & ~Zero);

  always_comb begin
    w_state_next = r_state;
    w_instr_ld   = 1'b0;
    w_pc_ld      = 1'b0;
    w_pc_sel     = 1'b0;
    w_bsel       = 1'b0;
    w_alu_func   = 4'b0000;
    w_rf_wr      = 1'b0;
    w_rf_sel     = 1'b0;
    w_mem_wr     = 1'b0;
    w_illegal    = 1'b0;
    case (r_state)
      S_IFETCH: begin
        w_instr_ld   = 1'b1;
        w_state_next = S_DECODE;
      end
      S_DECODE: begin
        if (w_is_nop) begin
          w_pc_ld      = 1'b1;
          w_state_next = S_IFETCH;
        end else if (w_is_illegal) begin
          w_illegal = 1'b1;
          if (ILLEGAL_TRAP != 0) begin
            w_state_next = S_HALT;
          end else begin
            w_pc_ld      = 1'b1;
            w_state_next = S_IFETCH;
          end
        end else begin
          w_state_next = S_EXEC;
        end
      end
      // ALU controls are held from EXEC through WB so the datapath sees them stable.
      S_EXEC: begin
        w_bsel     = w_dec_bsel;
        w_alu_func = w_dec_func;
        if (w_is_branch) begin
          w_pc_ld      = 1'b1;
          w_pc_sel     = w_branch_taken;
          w_state_next = S_IFETCH;
        end else if (w_is_lw || w_is_sw) begin
          w_state_next = S_MEM;
        end else begin
          w_state_next = S_WB;
        end
      end
      S_MEM: begin
        w_bsel     = w_dec_bsel;
        w_alu_func = w_dec_func;
        if (w_is_sw) begin
          w_mem_wr     = 1'b1;
          w_pc_ld      = 1'b1;
          w_state_next = S_IFETCH;
        end else begin
          w_state_next = S_WB;
        end
      end
      S_WB: begin
        w_bsel       = w_dec_bsel;
        w_alu_func   = w_dec_func;
        w_rf_wr      = 1'b1;
        w_rf_sel     = w_is_lw;
        w_pc_ld      = 1'b1;
        w_state_next = S_IFETCH;
      end
      S_HALT:  w_state_next = S_HALT;
      default: w_state_next = S_IFETCH;
    endcase
  end

  // Reset masks every output combinationally, even before the state register clears.
  assign Instr_LdEn    = w_instr_ld & ~Reset;
  assign PC_LdEn       = w_pc_ld & ~Reset;
  assign PC_sel        = w_pc_sel & ~Reset;
  assign ALU_Bin_SEL   = w_bsel & ~Reset;
  assign ALU_func      = Reset ? 4'b0000 : w_alu_func;
  assign RF_WrEn       = w_rf_wr & ~Reset;
  assign RF_WrData_sel = w_rf_sel & ~Reset;
  assign MEM_WrEn      = w_mem_wr & ~Reset;
  assign Illegal       = w_illegal & ~Reset;
  assign State         = Reset ? 3'd0 : r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: one instance with the default
// illegal-as-NOP behaviour and one with the halt trap, sharing all inputs.
module tb_multicycle_control;

  logic        Clk;
  logic        Reset;
  logic [31:0] Instr;
  logic        Zero;

  logic       m_ild, m_pld, m_psel, m_bsel, m_rfw, m_rfs, m_mw, m_ill;
  logic [3:0] m_fn;
  logic [2:0] m_st;
  logic       t_ild, t_pld, t_psel, t_bsel, t_rfw, t_rfs, t_mw, t_ill;
  logic [3:0] t_fn;
  logic [2:0] t_st;

  int n_vec  = 0;
  int n_miss = 0;

  localparam logic [31:0] I_ADD  = 32'h8022_1800;
  localparam logic [31:0] I_LW   = 32'h3C41_0008;
  localparam logic [31:0] I_SW   = 32'h7C41_000C;
  localparam logic [31:0] I_BEQ  = 32'h4022_0004;
  localparam logic [31:0] I_BNE  = 32'h4422_0004;
  localparam logic [31:0] I_B    = 32'hFC00_0010;
  localparam logic [31:0] I_ORI  = 32'hCC22_00FF;
  localparam logic [31:0] I_NOP  = 32'h0000_0000;
  localparam logic [31:0] I_ILL  = 32'hA800_0000;
  localparam logic [31:0] I_JUNK = 32'hFFFF_FFFF;

  multicycle_control u_dut (
    .Clk(Clk), .Reset(Reset), .Instr(Instr), .Zero(Zero),
    .Instr_LdEn(m_ild), .PC_LdEn(m_pld), .PC_sel(m_psel), .ALU_Bin_SEL(m_bsel),
    .ALU_func(m_fn), .RF_WrEn(m_rfw), .RF_WrData_sel(m_rfs), .MEM_WrEn(m_mw),
    .Illegal(m_ill), .State(m_st)
  );

  multicycle_control #(.ILLEGAL_TRAP(1)) u_trap (
    .Clk(Clk), .Reset(Reset), .Instr(Instr), .Zero(Zero),
    .Instr_LdEn(t_ild), .PC_LdEn(t_pld), .PC_sel(t_psel), .ALU_Bin_SEL(t_bsel),
    .ALU_func(t_fn), .RF_WrEn(t_rfw), .RF_WrData_sel(t_rfs), .MEM_WrEn(t_mw),
    .Illegal(t_ill), .State(t_st)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Expected output vector: {State, Instr_LdEn, PC_LdEn, PC_sel, ALU_Bin_SEL, ALU_func, RF_WrEn, RF_WrData_sel, MEM_WrEn, Illegal}
  function automatic logic [14:0] ev(input logic [2:0] st, input logic ild, input logic pld,
                                     input logic psel, input logic bsel, input logic [3:0] fn,
                                     input logic rfw, input logic rfs, input logic mw, input logic ill);
    return {st, ild, pld, psel, bsel, fn, rfw, rfs, mw, ill};
  endfunction

  task automatic chk(input bit trap, input string tag, input logic [14:0] expv);
    logic [14:0] obs;
    if (trap) obs = {t_st, t_ild, t_pld, t_psel, t_bsel, t_fn, t_rfw, t_rfs, t_mw, t_ill};
    else      obs = {m_st, m_ild, m_pld, m_psel, m_bsel, m_fn, m_rfw, m_rfs, m_mw, m_ill};
    n_vec++;
    assert (obs === expv) else begin
      n_miss++;
      $error("FAIL %s: observed %04h expected %04h", tag, obs, expv);
    end
  endtask

  task automatic chk_val(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_miss++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  initial begin
    Reset = 1'b1;
    Instr = I_NOP;
    Zero  = 1'b0;

    // Reset held: every output forced low
    tick(); Instr = I_ADD; #1;
    chk(0, "rst_hold", ev(3'd0,0,0,0,0,4'h0,0,0,0,0));
    chk(1, "rst_hold_t", ev(3'd0,0,0,0,0,4'h0,0,0,0,0));
    Reset = 1'b0; #1;
    chk(0, "rst_rel_if", ev(3'd0,1,0,0,0,4'h0,0,0,0,0));

    // R-type add: 0,1,2,4,0
    tick(); Instr = I_JUNK; #1;
    chk(0, "add_dec",  ev(3'd1,0,0,0,0,4'h0,0,0,0,0));
    tick(); #1; chk(0, "add_exec", ev(3'd2,0,0,0,0,4'h0,0,0,0,0));
    tick(); #1; chk(0, "add_wb",   ev(3'd4,0,1,0,0,4'h0,1,0,0,0));

    // lw: 0,1,2,3,4
    tick(); Instr = I_LW; #1; chk(0, "lw_if", ev(3'd0,1,0,0,0,4'h0,0,0,0,0));
    tick(); Instr = I_JUNK; #1; chk(0, "lw_dec", ev(3'd1,0,0,0,0,4'h0,0,0,0,0));
    tick(); #1; chk(0, "lw_exec", ev(3'd2,0,0,0,1,4'h0,0,0,0,0));
    tick(); #1; chk(0, "lw_mem",  ev(3'd3,0,0,0,1,4'h0,0,0,0,0));
    tick(); #1; chk(0, "lw_wb",   ev(3'd4,0,1,0,1,4'h0,1,1,0,0));

    // beq: Zero only matters in EXEC
    tick(); Instr = I_BEQ; Zero = 1'b1; #1; chk(0, "beq_if", ev(3'd0,1,0,0,0,4'h0,0,0,0,0));
    tick(); Instr = I_JUNK; #1; chk(0, "beq_dec", ev(3'd1,0,0,0,0,4'h0,0,0,0,0));
    tick(); Zero = 1'b0; #1; chk(0, "beq_z0", ev(3'd2,0,1,0,0,4'h1,0,0,0,0));
    Zero = 1'b1; #1;         chk(0, "beq_z1", ev(3'd2,0,1,1,0,4'h1,0,0,0,0));

    // bne
    tick(); Instr = I_BNE; #1; chk(0, "bne_if", ev(3'd0,1,0,0,0,4'h0,0,0,0,0));
    tick(); Instr = I_JUNK; #1;
    tick(); Zero = 1'b1; #1; chk(0, "bne_z1", ev(3'd2,0,1,0,0,4'h1,0,0,0,0));
    Zero = 1'b0; #1;         chk(0, "bne_z0", ev(3'd2,0,1,1,0,4'h1,0,0,0,0));

    // unconditional b, taken regardless of Zero
    tick(); Instr = I_B; Zero = 1'b1; #1; chk(0, "b_if", ev(3'd0,1,0,0,0,4'h0,0,0,0,0));
    tick(); Instr = I_NOP; #1;
    tick(); #1; chk(0, "b_exec", ev(3'd2,0,1,1,0,4'h0,0,0,0,0));

    // ori: immediate operand, func 0011
    tick(); Instr = I_ORI; #1; chk(0, "ori_if", ev(3'd0,1,0,0,0,4'h0,0,0,0,0));
    tick(); Instr = I_JUNK; #1;
    tick(); #1; chk(0, "ori_exec", ev(3'd2,0,0,0,1,4'h3,0,0,0,0));
    tick(); #1; chk(0, "ori_wb",   ev(3'd4,0,1,0,1,4'h3,1,0,0,0));

    // nop retires in DECODE
    tick(); Instr = I_NOP; #1; chk(0, "nop_if", ev(3'd0,1,0,0,0,4'h0,0,0,0,0));
    tick(); Instr = I_ILL; #1; chk(0, "nop_dec", ev(3'd1,0,1,0,0,4'h0,0,0,0,0));

    // illegal opcode 101010
    tick(); #1; chk(0, "ill_if", ev(3'd0,1,0,0,0,4'h0,0,0,0,0));
    tick(); Instr = I_NOP; #1;
    chk(0, "ill_dec", ev(3'd1,0,1,0,0,4'h0,0,0,0,1));
    chk_val("ill_dec_t", {4'h0, t_st, t_ill}, 8'h03);
    tick(); #1;
    chk(0, "ill_back_if", ev(3'd0,1,0,0,0,4'h0,0,0,0,0));
    chk(1, "halt_0", ev(3'd7,0,0,0,0,4'h0,0,0,0,0));
    for (int i = 1; i < 10; i++) begin
      tick(); Instr = (i % 2 == 0) ? I_ADD : I_SW; #1;
      chk(1, $sformatf("halt_%0d", i), ev(3'd7,0,0,0,0,4'h0,0,0,0,0));
    end

    // Reset clears HALT
    Reset = 1'b1; #1;
    chk(1, "halt_rst", ev(3'd0,0,0,0,0,4'h0,0,0,0,0));
    tick(); Instr = I_SW; #1;
    chk(0, "rst2", ev(3'd0,0,0,0,0,4'h0,0,0,0,0));
    Reset = 1'b0; #1;
    chk(1, "halt_exit", ev(3'd0,1,0,0,0,4'h0,0,0,0,0));
    chk(0, "sw_if", ev(3'd0,1,0,0,0,4'h0,0,0,0,0));

    // sw, reset asserted during MEM
    tick(); Instr = I_JUNK; #1; chk(0, "sw_dec", ev(3'd1,0,0,0,0,4'h0,0,0,0,0));
    tick(); #1; chk(0, "sw_exec", ev(3'd2,0,0,0,1,4'h0,0,0,0,0));
    tick(); #1; chk(0, "sw_mem",  ev(3'd3,0,1,0,1,4'h0,0,0,1,0));
    Reset = 1'b1; #1;
    chk(0, "sw_mem_rst", ev(3'd0,0,0,0,0,4'h0,0,0,0,0));
    tick(); Instr = I_NOP; #1;
    chk(0, "sw_rst_hold", ev(3'd0,0,0,0,0,4'h0,0,0,0,0));
    Reset = 1'b0; #1;
    chk(0, "sw_rst_rel", ev(3'd0,1,0,0,0,4'h0,0,0,0,0));
    tick(); #1;
    chk(0, "post_rst_dec", ev(3'd1,0,1,0,0,4'h0,0,0,0,0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

endmodule
